// File: rtl/pixel_riscv_soc_pkg.sv
// -----------------------------------------------------------------------------
// pixel_riscv_soc_pkg
// Shared definitions for the timer peripheral: register offsets within the
// TIMER slot, control-register bit positions, the register-file struct and a
// byte-enable merge helper used by every RW register.
// -----------------------------------------------------------------------------
package pixel_riscv_soc_pkg;

  // Register offsets from the TIMER slot base (byte addresses)
  localparam logic [11:0] TIMER_CR_OFFSET   = 12'h000;
  localparam logic [11:0] TIMER_SR_OFFSET   = 12'h004;
  localparam logic [11:0] TIMER_CNT_OFFSET  = 12'h008;
  localparam logic [11:0] TIMER_CMPR_OFFSET = 12'h00C;
  localparam logic [11:0] TIMER_PSC_OFFSET  = 12'h010;

  // CR bit positions
  localparam int TIMER_CR_EN_BIT  = 0;
  localparam int TIMER_CR_ARL_BIT = 1;
  localparam int TIMER_CR_IE_BIT  = 2;

  // Architectural register state; psc is kept 32 bits wide with the bits
  // above the configured prescaler width held at zero.
  typedef struct packed {
    logic [2:0]  cr;
    logic        sr;
    logic [31:0] cnt;
    logic [31:0] cmpr;
    logic [31:0] psc;
  } timer_regs_t;

  // Merge new_val into old_val one byte lane at a time under be
  function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_val[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/soc_timer_prescaler.sv
// -----------------------------------------------------------------------------
// soc_timer_prescaler
// Divides the clock by (psc + 1) while enabled and emits a one-cycle tick on
// the cycle the internal counter equals psc.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : count enable; when low the counter is held at zero
//   psc        : prescaler terminal value (psc = 0 -> tick every cycle)
//   psc_wr     : prescaler register is being written; restarts the count
//   tick       : one-cycle pulse that advances the main timer counter
// -----------------------------------------------------------------------------
module soc_timer_prescaler #(
  parameter int PSC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [PSC_WIDTH-1:0] psc,
  input  logic                 psc_wr,
  output logic                 tick
);

  localparam logic [PSC_WIDTH-1:0] PSC_ONE = {{(PSC_WIDTH-1){1'b0}}, 1'b1};

  logic [PSC_WIDTH-1:0] psc_cnt_r;
  logic [PSC_WIDTH-1:0] psc_cnt_next_s;
  logic                 wrap_s;

  assign wrap_s = (psc_cnt_r == psc);
  // Tick is combinational so the counter advances in the same cycle the
  // prescaler reaches its terminal value.
  assign tick   = en & wrap_s;

  // Next prescaler count: hold at zero when disabled or being reprogrammed
  always_comb begin
    psc_cnt_next_s = psc_cnt_r;
    if (!en || psc_wr) begin
      psc_cnt_next_s = {PSC_WIDTH{1'b0}};
    end else if (wrap_s) begin
      psc_cnt_next_s = {PSC_WIDTH{1'b0}};
    end else begin
      psc_cnt_next_s = psc_cnt_r + PSC_ONE;
    end
  end

  // Prescaler counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psc_cnt_r <= {PSC_WIDTH{1'b0}};
    end else begin
      psc_cnt_r <= psc_cnt_next_s;
    end
  end

endmodule

// File: rtl/soc_timer.sv
// -----------------------------------------------------------------------------
// soc_timer
// Memory-mapped 32-bit timer in the TIMER slot of the data bus. Provides a
// prescaled up-counter with compare match, optional auto-reload and a level
// interrupt.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req, we, be, addr,
//   wdata, wdata_intg     : request from the bus decoder (wdata_intg ignored)
//   gnt                   : grant, equal to req
//   rvalid, rdata, err    : registered response one cycle after the grant
//   rdata_intg            : integrity bits, tied to zero
//   irq                   : registered level interrupt (MATCH & IE)
// Register map (offset from base): 0x000 CR, 0x004 SR, 0x008 CNT,
// 0x00C CMPR, 0x010 PSC; anything else answers with err=1, rdata=0.
// -----------------------------------------------------------------------------
module soc_timer
  import pixel_riscv_soc_pkg::*;
#(
  parameter int          PSC_WIDTH  = 16,
  parameter logic [31:0] CMPR_RESET = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [6:0]  wdata_intg,
  output logic        gnt,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [6:0]  rdata_intg,
  output logic        err,
  output logic        irq
);

  localparam logic [31:0] PSC_MASK =
    (PSC_WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'd1 << PSC_WIDTH) - 32'd1);

  timer_regs_t regs_r;
  timer_regs_t regs_next_s;

  logic [9:0]  word_s;
  logic        sel_cr_s;
  logic        sel_sr_s;
  logic        sel_cnt_s;
  logic        sel_cmpr_s;
  logic        sel_psc_s;
  logic        hit_s;
  logic        wr_s;
  logic        rd_s;
  logic        tick_s;
  logic        match_s;
  logic        psc_wr_s;
  logic        sr_clr_s;
  logic [31:0] rd_mux_s;

  logic        rvalid_r;
  logic        err_r;
  logic        irq_r;
  logic [31:0] rdata_r;

  logic        unused_s;

  assign unused_s = ^{wdata_intg, addr[31:12], addr[1:0]};

  // Bus decode on the word index only
  assign word_s     = addr[11:2];
  assign sel_cr_s   = (word_s == TIMER_CR_OFFSET[11:2]);
  assign sel_sr_s   = (word_s == TIMER_SR_OFFSET[11:2]);
  assign sel_cnt_s  = (word_s == TIMER_CNT_OFFSET[11:2]);
  assign sel_cmpr_s = (word_s == TIMER_CMPR_OFFSET[11:2]);
  assign sel_psc_s  = (word_s == TIMER_PSC_OFFSET[11:2]);
  assign hit_s      = sel_cr_s | sel_sr_s | sel_cnt_s | sel_cmpr_s | sel_psc_s;

  assign wr_s     = req & we;
  assign rd_s     = req & ~we;
  assign psc_wr_s = wr_s & sel_psc_s;
  assign sr_clr_s = wr_s & sel_sr_s & wdata[0] & be[0];

  // Compare always uses the CMPR value before any same-cycle write
  assign match_s = (regs_r.cnt == regs_r.cmpr);

  soc_timer_prescaler #(
    .PSC_WIDTH (PSC_WIDTH)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (regs_r.cr[TIMER_CR_EN_BIT]),
    .psc    (regs_r.psc[PSC_WIDTH-1:0]),
    .psc_wr (psc_wr_s),
    .tick   (tick_s)
  );

  // Read mux over pre-update register state
  always_comb begin
    rd_mux_s = 32'd0;
    case (word_s)
      TIMER_CR_OFFSET[11:2]:   rd_mux_s = {29'd0, regs_r.cr};
      TIMER_SR_OFFSET[11:2]:   rd_mux_s = {31'd0, regs_r.sr};
      TIMER_CNT_OFFSET[11:2]:  rd_mux_s = regs_r.cnt;
      TIMER_CMPR_OFFSET[11:2]: rd_mux_s = regs_r.cmpr;
      TIMER_PSC_OFFSET[11:2]:  rd_mux_s = regs_r.psc;
      default:                 rd_mux_s = 32'd0;
    endcase
  end

  // Register next-state: bus writes, counter advance, match set / W1C
  always_comb begin
    regs_next_s = regs_r;

    if (wr_s && sel_cr_s && be[0]) begin
      regs_next_s.cr = wdata[2:0];
    end else begin
      regs_next_s.cr = regs_r.cr;
    end

    // A new match outranks a same-cycle clear so no event is lost
    if (tick_s && match_s) begin
      regs_next_s.sr = 1'b1;
    end else if (sr_clr_s) begin
      regs_next_s.sr = 1'b0;
    end else begin
      regs_next_s.sr = regs_r.sr;
    end

    // A bus write to CNT overrides the tick increment
    if (wr_s && sel_cnt_s) begin
      regs_next_s.cnt = apply_be(regs_r.cnt, wdata, be);
    end else if (tick_s) begin
      if (match_s && regs_r.cr[TIMER_CR_ARL_BIT]) begin
        regs_next_s.cnt = 32'd0;
      end else begin
        regs_next_s.cnt = regs_r.cnt + 32'd1;
      end
    end else begin
      regs_next_s.cnt = regs_r.cnt;
    end

    if (wr_s && sel_cmpr_s) begin
      regs_next_s.cmpr = apply_be(regs_r.cmpr, wdata, be);
    end else begin
      regs_next_s.cmpr = regs_r.cmpr;
    end

    if (psc_wr_s) begin
      regs_next_s.psc = apply_be(regs_r.psc, wdata, be) & PSC_MASK;
    end else begin
      regs_next_s.psc = regs_r.psc;
    end
  end

  // Register file, response path and interrupt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_r   <= '{cr: 3'd0, sr: 1'b0, cnt: 32'd0, cmpr: CMPR_RESET, psc: 32'd0};
      rvalid_r <= 1'b0;
      err_r    <= 1'b0;
      rdata_r  <= 32'd0;
      irq_r    <= 1'b0;
    end else begin
      regs_r   <= regs_next_s;
      rvalid_r <= req;
      err_r    <= req & ~hit_s;
      rdata_r  <= (rd_s && hit_s) ? rd_mux_s : 32'd0;
      irq_r    <= regs_r.sr & regs_r.cr[TIMER_CR_IE_BIT];
    end
  end

  assign gnt        = req;
  assign rvalid     = rvalid_r;
  assign err        = err_r;
  assign rdata      = rdata_r;
  assign rdata_intg = 7'd0;
  assign irq        = irq_r;

endmodule

// File: tb/tb_soc_timer.sv
// -----------------------------------------------------------------------------
// tb_soc_timer
// Self-checking bench for soc_timer. Requests push their expected response
// onto a scoreboard queue; a negedge monitor pops and compares every rvalid.
// -----------------------------------------------------------------------------
module tb_soc_timer;

  localparam logic [31:0] BASE = 32'h0100_3000;
  localparam logic [31:0] A_CR   = BASE + 32'h000;
  localparam logic [31:0] A_SR   = BASE + 32'h004;
  localparam logic [31:0] A_CNT  = BASE + 32'h008;
  localparam logic [31:0] A_CMPR = BASE + 32'h00C;
  localparam logic [31:0] A_PSC  = BASE + 32'h010;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [6:0]  wdata_intg;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic [6:0]  rdata_intg;
  logic        err;
  logic        irq;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  vec_t vecs[14];
  exp_t sb_q[$];
  int   tests;
  int   fails;
  logic mon_en;
  logic req_q;

  soc_timer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .we         (we),
    .be         (be),
    .addr       (addr),
    .wdata      (wdata),
    .wdata_intg (wdata_intg),
    .gnt        (gnt),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .rdata_intg (rdata_intg),
    .err        (err),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus request, driven at the negedge, expected response queued
  task automatic bus(input logic w, input logic [3:0] b, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] er, input logic ee);
    exp_t e;
    @(negedge clk);
    req = 1'b1; we = w; be = b; addr = a; wdata = d;
    e.rdata = er;
    e.err   = ee;
    sb_q.push_back(e);
    #1;
    chk("gnt", {31'd0, gnt}, 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    req = 1'b0; we = 1'b0;
    #1;
    chk("gnt_idle", {31'd0, gnt}, 32'd0);
  endtask

  // Request seen at each active edge -> expected rvalid for the next cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) req_q <= 1'b0;
    else        req_q <= req;
  end

  // Response monitor / scoreboard pop
  always @(negedge clk) begin
    exp_t e;
    if (mon_en && rst_n) begin
      if (req_q || rvalid) begin
        chk("rvalid", {31'd0, rvalid}, {31'd0, req_q});
      end
      if (rvalid) begin
        if (sb_q.size() == 0) begin
          chk("stray_rsp_queue", 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          chk("rdata", rdata, e.rdata);
          chk("err", {31'd0, err}, {31'd0, e.err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    tests = 0; fails = 0; mon_en = 1'b1;
    req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'd0; wdata = 32'd0; wdata_intg = 7'd0;
    rst_n = 1'b0;

    // Reset reads, partial writes, bad offsets (timer disabled throughout)
    vecs[0]  = '{1'b0, 4'hF, A_CR,   32'd0,          32'd0,          1'b0};
    vecs[1]  = '{1'b0, 4'hF, A_SR,   32'd0,          32'd0,          1'b0};
    vecs[2]  = '{1'b0, 4'hF, A_CNT,  32'd0,          32'd0,          1'b0};
    vecs[3]  = '{1'b0, 4'hF, A_CMPR, 32'd0,          32'hFFFF_FFFF,  1'b0};
    vecs[4]  = '{1'b0, 4'hF, A_PSC,  32'd0,          32'd0,          1'b0};
    vecs[5]  = '{1'b1, 4'h5, A_CMPR, 32'hAABB_CCDD,  32'd0,          1'b0};
    vecs[6]  = '{1'b0, 4'hF, A_CMPR, 32'd0,          32'hFFBB_FFDD,  1'b0};
    vecs[7]  = '{1'b1, 4'hF, BASE + 32'h020, 32'h1234_5678, 32'd0,   1'b1};
    vecs[8]  = '{1'b0, 4'hF, BASE + 32'h020, 32'd0,  32'd0,          1'b1};
    vecs[9]  = '{1'b0, 4'hF, A_CMPR, 32'd0,          32'hFFBB_FFDD,  1'b0};
    vecs[10] = '{1'b1, 4'hF, A_PSC,  32'h0001_2345,  32'd0,          1'b0};
    vecs[11] = '{1'b0, 4'hF, A_PSC,  32'd0,          32'h0000_2345,  1'b0};
    vecs[12] = '{1'b1, 4'h0, A_CR,   32'h0000_0007,  32'd0,          1'b0};
    vecs[13] = '{1'b0, 4'hF, BASE + 32'hFFC, 32'd0,  32'd0,          1'b1};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      bus(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
          vecs[i].exp_rdata, vecs[i].exp_err);
    end
    // CR must still read 0 after the be=0 write
    bus(1'b0, 4'hF, A_CR, 32'd0, 32'd0, 1'b0);

    // Auto-reload: PSC=3, CMPR=5, CR=EN|ARL|IE -> tick every 4 cycles
    bus(1'b1, 4'hF, A_PSC,  32'd3, 32'd0, 1'b0);
    bus(1'b1, 4'hF, A_CMPR, 32'd5, 32'd0, 1'b0);
    bus(1'b1, 4'hF, A_CR,   32'd7, 32'd0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      e = (i < 24) ? 32'(i / 4) : 32'((i - 24) / 4);
      bus(1'b0, 4'hF, A_CNT, 32'd0, e, 1'b0);
      chk("irq_arl", {31'd0, irq}, (i >= 25) ? 32'd1 : 32'd0);
    end
    bus(1'b0, 4'hF, A_SR, 32'd0, 32'd1, 1'b0);
    bus(1'b1, 4'hF, A_SR, 32'd1, 32'd0, 1'b0);
    bus(1'b0, 4'hF, A_SR, 32'd0, 32'd0, 1'b0);
    chk("irq_hold_after_clr", {31'd0, irq}, 32'd1);

    // No auto-reload, wrap through 0xFFFF_FFFF, IE=0
    bus(1'b1, 4'hF, A_CR, 32'd0, 32'd0, 1'b0);
    chk("irq_fall", {31'd0, irq}, 32'd0);
    bus(1'b1, 4'hF, A_CMPR, 32'd2,         32'd0, 1'b0);
    bus(1'b1, 4'hF, A_CNT,  32'hFFFF_FFFE, 32'd0, 1'b0);
    bus(1'b1, 4'hF, A_PSC,  32'd0,         32'd0, 1'b0);
    bus(1'b1, 4'hF, A_CR,   32'd1,         32'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      e = 32'hFFFF_FFFE + 32'(i);
      bus(1'b0, 4'hF, A_CNT, 32'd0, e, 1'b0);
      chk("irq_no_ie", {31'd0, irq}, 32'd0);
    end
    bus(1'b0, 4'hF, A_SR, 32'd0, 32'd1, 1'b0);

    // CNT write in a tick cycle; W1C coincident with a new match
    bus(1'b1, 4'hF, A_CNT,  32'h100, 32'd0,   1'b0);
    bus(1'b0, 4'hF, A_CNT,  32'd0,   32'h100, 1'b0);
    bus(1'b1, 4'hF, A_CMPR, 32'h103, 32'd0,   1'b0);
    bus(1'b1, 4'hF, A_SR,   32'd1,   32'd0,   1'b0);
    bus(1'b1, 4'hF, A_SR,   32'd1,   32'd0,   1'b0);
    bus(1'b0, 4'hF, A_SR,   32'd0,   32'd1,   1'b0);
    bus(1'b0, 4'hF, A_CNT,  32'd0,   32'h105, 1'b0);
    idle();
    idle();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    // Reset in the middle of back-to-back reads
    mon_en = 1'b0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; be = 4'hF; addr = A_CR;
    @(negedge clk);
    #1 chk("b2b_rvalid1", {31'd0, rvalid}, 32'd1);
    @(negedge clk);
    #1 chk("b2b_rvalid2", {31'd0, rvalid}, 32'd1);
    rst_n = 1'b0;
    #1 chk("rst_drop_rvalid", {31'd0, rvalid}, 32'd0);
    chk("rst_drop_irq", {31'd0, irq}, 32'd0);
    req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk("no_stray_rvalid", {31'd0, rvalid}, 32'd0);
    end
    mon_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wdata,
          vecs[i].exp_rdata, vecs[i].exp_err);
    end
    idle();
    idle();
    chk("sb_final_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/soc_timer.md
Name: soc_timer

Overview:
- Memory-mapped 32-bit timer peripheral on the data bus, in the TIMER slot at 0x0100_3000–0x0100_3FFF.
- Downstream of the data bus decoder/mux. Consumes the decoder's forwarded request (req/we/be/addr/wdata) and returns gnt, rvalid, rdata and err.
- Provides a prescaled up-counter, a compare match, optional auto-reload and a level interrupt to the core.

Parameters:
- PSC_WIDTH, 16, width of prescaler register and prescaler counter.
- CMPR_RESET, 32'hFFFF_FFFF, reset value of the compare register.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req  input  1  bus request; asserted only when the decoder selects this slave
- we  input  1  write enable
- be  input  4  byte enables
- addr  input  32  byte address; only addr[11:2] is decoded
- wdata  input  32  write data
- wdata_intg  input  7  integrity bits, ignored
- gnt  output  1  grant
- rvalid  output  1  response valid
- rdata  output  32  read data
- rdata_intg  output  7  integrity bits, tied to 0
- err  output  1  error response, valid with rvalid
- irq  output  1  timer interrupt, level

Behaviour:
- Reset values:
  - gnt, rvalid, err, irq are 0; rdata is 0.
  - CR=0, SR=0, CNT=0, CMPR=CMPR_RESET, PSC=0, prescaler counter=0.
- Register map (offsets from base):
  - 0x000 CR: [0] EN, [1] ARL (auto-reload), [2] IE (interrupt enable); other bits read 0.
  - 0x004 SR: [0] MATCH; write-1-to-clear.
  - 0x008 CNT: RW.
  - 0x00C CMPR: RW.
  - 0x010 PSC: RW, [PSC_WIDTH-1:0].
  - Any other offset: no state change; the response has err=1 and rdata=0.
- Handshake:
  - gnt = req, combinational. Every request is granted in the same cycle.
  - rvalid is asserted exactly 1 cycle after each granted request, for 1 cycle.
  - rdata and err are registered and valid only while rvalid=1; rdata is 0 otherwise.
  - Back-to-back requests are sustained: one response per cycle, no bubbles.
  - Write responses carry rdata=0.
- Writes:
  - Applied on the grant cycle and visible from the next cycle.
  - be[i] gates byte i.
  - SR clear uses wdata[0]&be[0].
- Reads: return register state as of the grant cycle, i.e. before that cycle's updates.
- Prescaler:
  - When EN=1, psc_cnt increments each cycle.
  - When psc_cnt==PSC, psc_cnt returns to 0 and a one-cycle tick is generated. PSC=0 therefore gives a tick every cycle.
  - When EN=0, psc_cnt is held at 0 and no ticks occur; CNT holds its value.
- Counter, on each tick:
  - If CNT==CMPR: MATCH is set. CNT becomes 0 if ARL=1, else CNT+1.
  - Otherwise CNT becomes CNT+1.
  - Arithmetic is modulo 2^32: 0xFFFF_FFFF wraps to 0 with no flag.
- Simultaneous events:
  - A bus write to CNT in the same cycle as a tick: the written value wins and the increment is lost.
  - A write to PSC resets psc_cnt to 0.
  - An SR W1C in the same cycle as a new match: set wins, MATCH stays 1.
  - A CMPR write in a tick cycle: the compare uses the old CMPR.
- irq = registered (MATCH & IE). It rises 1 cycle after MATCH is set (or after IE is set while MATCH=1). It falls 1 cycle after the clear.
- Reset is asynchronous. Reset mid-transaction drops any pending rvalid; no response is issued after reset deasserts.

Decomposition:
- Shared package (pixel_riscv_soc_pkg) holds:
  - register offset constants (TIMER_CR_OFFSET … TIMER_PSC_OFFSET);
  - CR bit-index constants;
  - a packed struct timer_regs_t {cr, sr, cnt, cmpr, psc}.
- Natural sub-module: soc_timer_prescaler (en, psc, psc_wr → tick).
- Bus decode and registers stay in soc_timer.

Test Plan:
- Reset, then read each register → CR=0, SR=0, CNT=0, CMPR=0xFFFF_FFFF, PSC=0. Each read: rvalid 1 cycle after gnt, err=0.
- PSC=3, CMPR=5, CR=0x7 (EN|ARL|IE) → CNT increments every 4 cycles. At the tick where CNT==5: MATCH=1 and CNT becomes 0. irq=1 one cycle later. Write SR=1 → irq=0 one cycle after.
- CR=0x1 (no ARL), CMPR=2, CNT written 0xFFFF_FFFE, PSC=0 → CNT reads 0xFFFF_FFFF, then 0, 1, 2, 3. MATCH is set on the tick at CNT=2; irq stays 0 (IE=0).
- Write CNT=0x100 in the same cycle as a tick → CNT reads 0x100, not 0x101. W1C of SR coincident with a match → SR reads 1.
- Write 0xAABBCCDD to CMPR with be=4'b0101, starting from 0xFFFF_FFFF → reads 0xFFBBFFDD. Access offset 0x020 → err=1, rdata=0, no register changes.
- Four back-to-back reads → four consecutive rvalid cycles. Assert rst_n=0 during the second → rvalid drops immediately; after release all registers are at reset values and no stray rvalid appears.
